// File: rtl/aes_key_expansion_ctrl.sv
// AES-128 key expansion: one round key per clock into a readable slot file, registered reads.
// Optional macro KEY_EXP_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_expansion_ctrl #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
`ifdef KEY_EXP_ZEROIZE_EN
   input  logic         zeroize,
`endif
   input  logic [127:0] key_in,
   input  logic         key_load,
   output logic         busy,
   output logic         keys_valid,
   input  logic         rd_en,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key,
   output logic         rd_valid
);

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
      x2   = gf_mul(b, b);
      x4   = gf_mul(x2, x2);
      x8   = gf_mul(x4, x4);
      x16  = gf_mul(x8, x8);
      x32  = gf_mul(x16, x16);
      x64  = gf_mul(x32, x32);
      x128 = gf_mul(x64, x64);
      inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                    gf_mul(gf_mul(x32, x64), x128));
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] key_round(input logic [127:0] kw, input logic [3:0] rnd);
      logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
      {w0, w1, w2, w3} = kw;
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      t  = t ^ {rcon(rnd), 24'h000000};
      n0 = w0 ^ t;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   state_t         r_state;
   logic [3:0]     r_cnt;
   logic [127:0]   r_slot [0:NUM_ROUNDS];
   logic           r_busy;
   logic           r_keys_valid;
   logic [127:0]   r_rd_key;
   logic           r_rd_valid;

   logic [3:0]     w_prev_idx;
   logic [127:0]   w_next;
   logic           w_zeroize;

`ifdef KEY_EXP_ZEROIZE_EN
   assign w_zeroize = zeroize;
`else
   assign w_zeroize = 1'b0;
`endif

   assign w_prev_idx = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
   assign w_next     = key_round(r_slot[w_prev_idx], r_cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_busy       <= 1'b0;
         r_keys_valid <= 1'b0;
         r_rd_key     <= '0;
         r_rd_valid   <= 1'b0;
         for (int i = 0; i <= NUM_ROUNDS; i++) r_slot[i] <= '0;
      end else if (w_zeroize) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_busy       <= 1'b0;
         r_keys_valid <= 1'b0;
         r_rd_key     <= '0;
         r_rd_valid   <= 1'b0;
         for (int i = 0; i <= NUM_ROUNDS; i++) r_slot[i] <= '0;
      end else begin
         // Reads sample slot contents before this edge's write lands.
         r_rd_valid <= rd_en;
         if (rd_en) r_rd_key <= (rd_round <= LAST) ? r_slot[rd_round] : '0;

         case (r_state)
            S_IDLE, S_DONE: begin
               if (key_load) begin
                  r_slot[0]    <= key_in;
                  r_cnt        <= 4'd1;
                  r_keys_valid <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= S_EXPAND;
               end
            end
            S_EXPAND: begin
               r_slot[r_cnt] <= w_next;
               if (r_cnt == LAST) begin
                  r_busy       <= 1'b0;
                  r_keys_valid <= 1'b1;
                  r_state      <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy       = r_busy;
   assign keys_valid = r_keys_valid;
   assign rd_key     = r_rd_key;
   assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_aes_key_expansion_ctrl.sv
// Directed bench for aes_key_expansion_ctrl using FIPS-197 key-expansion vectors.
module tb_aes_key_expansion_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key_in;
   logic         key_load;
   logic         busy;
   logic         keys_valid;
   logic         rd_en;
   logic [3:0]   rd_round;
   logic [127:0] rd_key;
   logic         rd_valid;
`ifdef KEY_EXP_ZEROIZE_EN
   logic         zeroize;
`endif

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KB = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KA_R [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   aes_key_expansion_ctrl #(.NUM_ROUNDS(10)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef KEY_EXP_ZEROIZE_EN
      .zeroize    (zeroize),
`endif
      .key_in     (key_in),
      .key_load   (key_load),
      .busy       (busy),
      .keys_valid (keys_valid),
      .rd_en      (rd_en),
      .rd_round   (rd_round),
      .rd_key     (rd_key),
      .rd_valid   (rd_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [127:0] k);
      key_in   = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [3:0] rnd, input logic [127:0] exp);
      rd_en    = 1'b1;
      rd_round = rnd;
      tick();
      rd_en    = 1'b0;
      check({tag, "_valid"}, 128'(rd_valid), 128'd1);
      check({tag, "_key"}, rd_key, exp);
   endtask

   initial begin
      rst      = 1'b1;
      key_in   = '0;
      key_load = 1'b0;
      rd_en    = 1'b0;
      rd_round = 4'd0;
`ifdef KEY_EXP_ZEROIZE_EN
      zeroize  = 1'b0;
`endif
      #3;
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_kv", 128'(keys_valid), 128'd0);
      check("reset_rdkey", rd_key, 128'd0);
      check("reset_rdvalid", 128'(rd_valid), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // FIPS-197 key: latency and contents
      load(KA);
      check("load_busy", 128'(busy), 128'd1);
      check("load_kv", 128'(keys_valid), 128'd0);
      for (int i = 1; i <= 9; i++) begin
         tick();
         check($sformatf("exp_busy_%0d", i), 128'(busy), 128'd1);
         check($sformatf("exp_kv_%0d", i), 128'(keys_valid), 128'd0);
      end
      tick();
      check("done_busy", 128'(busy), 128'd0);
      check("done_kv", 128'(keys_valid), 128'd1);

      // back-to-back reads over all rounds
      rd_en = 1'b1;
      for (int r = 0; r <= 10; r++) begin
         rd_round = 4'(r);
         tick();
         check($sformatf("b2b_valid_%0d", r), 128'(rd_valid), 128'd1);
         check($sformatf("b2b_key_%0d", r), rd_key, KA_R[r]);
      end
      rd_en = 1'b0;
      tick();
      check("idle_rdvalid", 128'(rd_valid), 128'd0);
      check("idle_rdkey_hold", rd_key, KA_R[10]);

      read_check("oor11", 4'd11, 128'd0);
      read_check("oor15", 4'd15, 128'd0);

      // restart from DONE with all-zero key; read-before-write on slot 1
      load(128'd0);
      check("restart_kv", 128'(keys_valid), 128'd0);
      check("restart_busy", 128'(busy), 128'd1);
      read_check("rbw_r1", 4'd1, KA_R[1]);
      for (int i = 2; i <= 9; i++) tick();
      check("restart_busy_t9", 128'(busy), 128'd1);
      tick();
      check("restart_done_kv", 128'(keys_valid), 128'd1);
      read_check("zero_r0", 4'd0, 128'd0);
      read_check("zero_r1", 4'd1, 128'h62636363626363636263636362636363);
      read_check("zero_r10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

      // load during EXPAND is ignored
      load(KA);
      tick();
      tick();
      load(KB);
      for (int i = 4; i <= 9; i++) tick();
      check("ign_kv_t9", 128'(keys_valid), 128'd0);
      check("ign_busy_t9", 128'(busy), 128'd1);
      tick();
      check("ign_kv_t10", 128'(keys_valid), 128'd1);
      read_check("ign_r0", 4'd0, KA_R[0]);
      read_check("ign_r1", 4'd1, KA_R[1]);
      read_check("ign_r10", 4'd10, KA_R[10]);

      // reset in flight
      load(KB);
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rstmid_busy", 128'(busy), 128'd0);
      check("rstmid_kv", 128'(keys_valid), 128'd0);
      check("rstmid_rdkey", rd_key, 128'd0);
      check("rstmid_rdvalid", 128'(rd_valid), 128'd0);
      tick();
      rst = 1'b0;
      tick();
      for (int r = 0; r <= 10; r++) read_check($sformatf("rstmid_r%0d", r), 4'(r), 128'd0);
      check("rstmid_idle_busy", 128'(busy), 128'd0);
      load(KA);
      for (int i = 1; i <= 10; i++) tick();
      check("after_rst_kv", 128'(keys_valid), 128'd1);
      read_check("after_rst_r10", 4'd10, KA_R[10]);

`ifdef KEY_EXP_ZEROIZE_EN
      load(KA);
      for (int i = 1; i <= 4; i++) tick();
      zeroize  = 1'b1;
      key_load = 1'b1;
      key_in   = KB;
      rd_en    = 1'b1;
      rd_round = 4'd0;
      tick();
      zeroize  = 1'b0;
      key_load = 1'b0;
      rd_en    = 1'b0;
      check("zer_busy", 128'(busy), 128'd0);
      check("zer_kv", 128'(keys_valid), 128'd0);
      check("zer_rdvalid", 128'(rd_valid), 128'd0);
      check("zer_rdkey", rd_key, 128'd0);
      tick();
      check("zer_no_load", 128'(busy), 128'd0);
      for (int r = 0; r <= 10; r++) read_check($sformatf("zer_r%0d", r), 4'(r), 128'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
